// File: rtl/param_wormhole_router_pkg.sv
// Shared definitions for the parametrised wormhole router: port indices,
// input-unit state encoding, XY route decode and round-robin pick helper.
package param_wormhole_router_pkg;

  localparam int unsigned NumPorts  = 5;
  localparam int unsigned PortLocal = 0;
  localparam int unsigned PortNorth = 1;
  localparam int unsigned PortSouth = 2;
  localparam int unsigned PortEast  = 3;
  localparam int unsigned PortWest  = 4;

  typedef enum logic [1:0] {StIdle, StReq, StXfer} in_state_e;

  // One-hot output request for a head flit; X is resolved before Y.
  function automatic logic [NumPorts-1:0] xy_route(input int unsigned dest_x,
                                                   input int unsigned dest_y,
                                                   input int unsigned node_x,
                                                   input int unsigned node_y);
    logic [NumPorts-1:0] r;
    r = '0;
    if (dest_x > node_x)      r[PortEast]  = 1'b1;
    else if (dest_x < node_x) r[PortWest]  = 1'b1;
    else if (dest_y > node_y) r[PortNorth] = 1'b1;
    else if (dest_y < node_y) r[PortSouth] = 1'b1;
    else                      r[PortLocal] = 1'b1;
    return r;
  endfunction

  // Returns {hit, index} of the first request at or after ptr, wrapping at NumPorts.
  function automatic logic [3:0] rr_pick(input logic [NumPorts-1:0] reqs,
                                         input logic [2:0] ptr);
    logic [3:0] res;
    int i;
    res = '0;
    // Walk from the farthest offset down so the nearest requester wins.
    for (int k = NumPorts - 1; k >= 0; k--) begin
      i = int'(ptr) + k;
      if (i >= int'(NumPorts)) i = i - int'(NumPorts);
      if (reqs[i]) res = {1'b1, 3'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/param_wormhole_router_if.sv
// Router-side bundle: five input channels (flit/valid in, full/drop out) and
// five output channels (flit/valid/busy out, full in). Port p occupies slice
// [p*FLIT_WIDTH +: FLIT_WIDTH]; bit order is local, north, south, east, west.
// slave  : the router.
// master : whatever drives the router (neighbours, neuron core, bench).
interface param_wormhole_router_if #(
  parameter int unsigned FLIT_WIDTH = 8
);
  logic [5*FLIT_WIDTH-1:0] in_flit;
  logic [4:0]              in_valid;
  logic [4:0]              in_full;
  logic [4:0]              in_drop;
  logic [5*FLIT_WIDTH-1:0] out_flit;
  logic [4:0]              out_valid;
  logic [4:0]              out_full;
  logic [4:0]              out_busy;

  modport slave (
    input  in_flit, in_valid, out_full,
    output in_full, in_drop, out_flit, out_valid, out_busy
  );

  modport master (
    output in_flit, in_valid, out_full,
    input  in_full, in_drop, out_flit, out_valid, out_busy
  );
endinterface

// File: rtl/param_wormhole_router_input_unit.sv
// One router input: synchronous FIFO, packet flit counter, XY route decode of
// the head flit and the IDLE/REQ/XFER state machine.
// Ports: flit_i/valid_i write side, full_o/drop_o status, pop_i from the
// output side, empty_o/head_o FIFO head, req_o one-hot route request (REQ
// only), last_o set while the next pop ends the packet (XFER only).
module param_wormhole_router_input_unit
  import param_wormhole_router_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH       = 8,
  parameter int unsigned COORD_W          = 4,
  parameter int unsigned FLITS_PER_PACKET = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned X_COORDINATE     = 1,
  parameter int unsigned Y_COORDINATE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLIT_WIDTH-1:0] flit_i,
  input  logic                  valid_i,
  output logic                  full_o,
  output logic                  drop_o,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic [FLIT_WIDTH-1:0] head_o,
  output logic [NumPorts-1:0]   req_o,
  output logic                  last_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned PktW = $clog2(FLITS_PER_PACKET + 1);

  logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  drop_q;
  logic                  push;
  in_state_e             state_q;
  logic [PktW-1:0]       pkt_cnt_q;
  logic [COORD_W-1:0]    dest_x, dest_y;

  assign full_o  = (count_q == CntW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign push    = valid_i & ~full_o;
  assign drop_o  = drop_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_d = count_q + CntW'(push) - CntW'(pop_i);

  assign dest_x = head_o[2*COORD_W-1:COORD_W];
  assign dest_y = head_o[COORD_W-1:0];
  assign req_o  = (state_q == StReq) ?
                  xy_route(32'(dest_x), 32'(dest_y), X_COORDINATE, Y_COORDINATE) : '0;
  assign last_o = (state_q == StXfer) && (pkt_cnt_q == PktW'(FLITS_PER_PACKET - 1));

  // Storage needs no reset; emptiness is carried by count_q.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= flit_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (push)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      drop_q  <= valid_i & full_o;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pkt_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: if (!empty_o) state_q <= StReq;
        StReq: begin
          // pop_i in REQ is the grant; the head leaves this cycle.
          if (pop_i) begin
            if (FLITS_PER_PACKET == 1) begin
              state_q <= (count_d != '0) ? StReq : StIdle;
            end else begin
              state_q   <= StXfer;
              pkt_cnt_q <= PktW'(1);
            end
          end
        end
        StXfer: begin
          if (pop_i) begin
            if (last_o) begin
              pkt_cnt_q <= '0;
              state_q   <= (count_d != '0) ? StReq : StIdle;
            end else begin
              pkt_cnt_q <= pkt_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/param_wormhole_router.sv
// Parametrised 5-port wormhole router with per-input FIFOs, XY routing and
// per-output round-robin arbitration; an output stays locked to one input for
// a whole packet.
// Ports: clk, reset (async, active-high), noc_io (slave side of the router
// interface: per-port input flit/valid/full/drop and output flit/valid/busy/full).
module param_wormhole_router
  import param_wormhole_router_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH       = 8,
  parameter int unsigned COORD_W          = 4,
  parameter int unsigned FLITS_PER_PACKET = 4,
  parameter int unsigned FIFO_DEPTH       = 4,
  parameter int unsigned X_COORDINATE     = 1,
  parameter int unsigned Y_COORDINATE     = 1
) (
  input logic                   clk,
  input logic                   reset,
  param_wormhole_router_if.slave noc_io
);

  logic [NumPorts-1:0]                 empty, last, pop, in_full, in_drop;
  logic [NumPorts-1:0][FLIT_WIDTH-1:0] head_row;
  logic [NumPorts-1:0][NumPorts-1:0]   req_row, req_col;

  logic [NumPorts-1:0]                 lock_q, lock_d, xfer, busy_q, valid_q;
  logic [NumPorts-1:0][2:0]            ptr_q, ptr_d, owner_q, owner_d, src;
  logic [NumPorts-1:0][FLIT_WIDTH-1:0] flit_q;

  for (genvar g = 0; g < NumPorts; g++) begin : g_port
    param_wormhole_router_input_unit #(
      .FLIT_WIDTH      (FLIT_WIDTH),
      .COORD_W         (COORD_W),
      .FLITS_PER_PACKET(FLITS_PER_PACKET),
      .FIFO_DEPTH      (FIFO_DEPTH),
      .X_COORDINATE    (X_COORDINATE),
      .Y_COORDINATE    (Y_COORDINATE)
    ) u_in (
      .clk    (clk),
      .reset  (reset),
      .flit_i (noc_io.in_flit[g*FLIT_WIDTH +: FLIT_WIDTH]),
      .valid_i(noc_io.in_valid[g]),
      .full_o (in_full[g]),
      .drop_o (in_drop[g]),
      .pop_i  (pop[g]),
      .empty_o(empty[g]),
      .head_o (head_row[g]),
      .req_o  (req_row[g]),
      .last_o (last[g])
    );

    assign noc_io.out_flit[g*FLIT_WIDTH +: FLIT_WIDTH] = flit_q[g];
  end

  assign noc_io.in_full   = in_full;
  assign noc_io.in_drop   = in_drop;
  assign noc_io.out_valid = valid_q;
  assign noc_io.out_busy  = busy_q;

  always_comb begin
    for (int o = 0; o < NumPorts; o++) begin
      for (int i = 0; i < NumPorts; i++) req_col[o][i] = req_row[i][o];
    end
  end

  always_comb begin
    logic [3:0] pick;
    pick    = '0;
    pop     = '0;
    xfer    = '0;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    src     = owner_q;
    for (int o = 0; o < NumPorts; o++) begin
      pick = rr_pick(req_col[o], ptr_q[o]);
      if (!lock_q[o]) begin
        // A full output neither grants nor blocks other outputs.
        if (!noc_io.out_full[o] && pick[3]) begin
          xfer[o]    = 1'b1;
          src[o]     = pick[2:0];
          owner_d[o] = pick[2:0];
          ptr_d[o]   = (pick[2:0] == 3'(NumPorts - 1)) ? 3'd0 : pick[2:0] + 3'd1;
          // A single-flit packet is finished on its grant cycle.
          lock_d[o]  = (FLITS_PER_PACKET > 1);
        end
      end else if (!empty[owner_q[o]] && !noc_io.out_full[o]) begin
        xfer[o] = 1'b1;
        if (last[owner_q[o]]) lock_d[o] = 1'b0;
      end
      if (xfer[o]) pop[src[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q  <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      valid_q <= '0;
      busy_q  <= '0;
      flit_q  <= '0;
    end else begin
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      valid_q <= xfer;
      // Busy is aligned with the registered flit stream: it covers every
      // cycle from the head's out_valid through the tail's out_valid.
      busy_q  <= lock_d | xfer;
      for (int o = 0; o < NumPorts; o++) begin
        if (xfer[o]) flit_q[o] <= head_row[src[o]];
      end
    end
  end

endmodule

// File: tb/tb_param_wormhole_router.sv
module tb_param_wormhole_router;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  param_wormhole_router_if #(.FLIT_WIDTH(8)) nif ();

  param_wormhole_router #(
    .FLIT_WIDTH      (8),
    .COORD_W         (4),
    .FLITS_PER_PACKET(4),
    .FIFO_DEPTH      (4),
    .X_COORDINATE    (1),
    .Y_COORDINATE    (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .noc_io(nif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  logic [7:0] oq [5][$];
  int         tq [5][$];
  int         busy_cnt [5];
  int         drop_cnt [5];

  always @(negedge clk) begin
    for (int p = 0; p < 5; p++) begin
      if (nif.out_valid[p]) begin
        oq[p].push_back(nif.out_flit[p*8 +: 8]);
        tq[p].push_back(cyc);
      end
      if (nif.out_busy[p]) busy_cnt[p]++;
      if (nif.in_drop[p])  drop_cnt[p]++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic clear_mon();
    for (int p = 0; p < 5; p++) begin
      oq[p].delete();
      tq[p].delete();
      busy_cnt[p] = 0;
      drop_cnt[p] = 0;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    nif.in_valid = '0;
    nif.in_flit  = '0;
    nif.out_full = '0;
    idle(2);
    reset = 1'b0;
    step();
    clear_mon();
  endtask

  function automatic int total_out();
    int s = 0;
    for (int p = 0; p < 5; p++) s += oq[p].size();
    return s;
  endfunction

  // Checks port p carried exactly the flits in exp[0..n-1], the first at t0,
  // back to back.
  task automatic check_stream(input string tag, input int p, input logic [7:0] exp[8],
                              input int n, input int t0);
    check({tag, "_count"}, oq[p].size(), n);
    for (int i = 0; i < n && i < oq[p].size(); i++) begin
      check($sformatf("%s_flit%0d", tag, i), oq[p][i], exp[i]);
      check($sformatf("%s_time%0d", tag, i), tq[p][i], t0 + i);
    end
  endtask

  task automatic send_pkt(input int p, input logic [7:0] h, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, output int c0);
    logic [7:0] fl [4];
    fl = '{h, b1, b2, b3};
    c0 = 0;
    for (int i = 0; i < 4; i++) begin
      nif.in_valid    = '0;
      nif.in_valid[p] = 1'b1;
      nif.in_flit[p*8 +: 8] = fl[i];
      step();
      if (i == 0) c0 = cyc;
    end
    nif.in_valid = '0;
  endtask

  logic [7:0] exp8 [8];
  logic [7:0] heads [5] = '{8'h21, 8'h01, 8'h12, 8'h10, 8'h11};
  int         dests [5] = '{3, 4, 1, 2, 0};

  initial begin
    int c0;
    logic [7:0] nf [4];
    logic [7:0] wf [4];
    logic [7:0] sf [6];

    reset        = 1'b1;
    nif.in_valid = '0;
    nif.in_flit  = '0;
    nif.out_full = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", nif.out_valid, 0);
    check("rst_out_busy", nif.out_busy, 0);
    check("rst_out_flit", nif.out_flit, 0);
    check("rst_in_full", nif.in_full, 0);
    check("rst_in_drop", nif.in_drop, 0);

    // Local -> east, 2-cycle latency, back-to-back body
    send_pkt(0, 8'h21, 8'hA1, 8'hA2, 8'hA3, c0);
    idle(6);
    exp8 = '{8'h21, 8'hA1, 8'hA2, 8'hA3, 0, 0, 0, 0};
    check_stream("east", 3, exp8, 4, c0 + 2);
    check("east_busy_cycles", busy_cnt[3], 4);
    check("east_only", total_out(), 4);

    // North and west to local in the same cycle: north first, no interleave
    do_reset();
    nf = '{8'h11, 8'hB1, 8'hB2, 8'hB3};
    wf = '{8'h11, 8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 4; i++) begin
      nif.in_valid = 5'b10010;
      nif.in_flit[8 +: 8]  = nf[i];
      nif.in_flit[32 +: 8] = wf[i];
      step();
      if (i == 0) c0 = cyc;
    end
    nif.in_valid = '0;
    idle(12);
    exp8 = '{8'h11, 8'hB1, 8'hB2, 8'hB3, 8'h11, 8'hC1, 8'hC2, 8'hC3};
    check_stream("arb", 0, exp8, 8, c0 + 2);
    check("arb_no_drop", drop_cnt[1] + drop_cnt[4], 0);

    // East stalled mid-packet by out_full
    do_reset();
    wf = '{8'h21, 8'hA1, 8'hA2, 8'hA3};
    for (int i = 0; i < 4; i++) begin
      nif.in_valid = 5'b00001;
      nif.in_flit[0 +: 8] = wf[i];
      if (i == 3) nif.out_full[3] = 1'b1;
      step();
      if (i == 0) c0 = cyc;
    end
    nif.in_valid = '0;
    check("stall_busy_held", nif.out_busy[3], 1);
    idle(3);
    nif.out_full[3] = 1'b0;
    idle(6);
    check("stall_count", oq[3].size(), 4);
    for (int i = 0; i < 4 && i < oq[3].size(); i++) begin
      check($sformatf("stall_flit%0d", i), oq[3][i], wf[i]);
      check($sformatf("stall_time%0d", i), tq[3][i], (i == 0) ? c0 + 2 : c0 + 6 + i);
    end
    check("stall_no_drop", drop_cnt[0], 0);

    // South FIFO overflow while east is blocked
    do_reset();
    nif.out_full[3] = 1'b1;
    sf = '{8'h21, 8'hD1, 8'hD2, 8'hD3, 8'hE0, 8'hE1};
    for (int i = 0; i < 6; i++) begin
      nif.in_valid = 5'b00100;
      nif.in_flit[16 +: 8] = sf[i];
      step();
      if (i == 2) check("ovf_full_after3", nif.in_full[2], 0);
      if (i == 3) check("ovf_full_after4", nif.in_full[2], 1);
    end
    nif.in_valid = '0;
    idle(2);
    check("ovf_drops", drop_cnt[2], 2);
    check("ovf_blocked_out", oq[3].size(), 0);
    nif.out_full[3] = 1'b0;
    idle(8);
    check("ovf_count", oq[3].size(), 4);
    for (int i = 0; i < 4 && i < oq[3].size(); i++) begin
      check($sformatf("ovf_flit%0d", i), oq[3][i], sf[i]);
    end
    check("ovf_full_cleared", nif.in_full[2], 0);

    // Reset in the middle of a packet
    do_reset();
    send_pkt(0, 8'h21, 8'hA1, 8'hA2, 8'hA3, c0);
    reset = 1'b1;
    #2;
    check("mid_rst_valid", nif.out_valid, 0);
    check("mid_rst_busy", nif.out_busy, 0);
    check("mid_rst_flit", nif.out_flit, 0);
    check("mid_rst_full", nif.in_full, 0);
    idle(2);
    reset = 1'b0;
    clear_mon();
    idle(6);
    check("mid_rst_flushed", total_out(), 0);
    send_pkt(0, 8'h01, 8'hF1, 8'hF2, 8'hF3, c0);
    idle(6);
    exp8 = '{8'h01, 8'hF1, 8'hF2, 8'hF3, 0, 0, 0, 0};
    check_stream("post_rst", 4, exp8, 4, c0 + 2);

    // XY route table from the local port
    for (int d = 0; d < 5; d++) begin
      clear_mon();
      send_pkt(0, heads[d], 8'h5A, 8'h5B, 8'h5C, c0);
      idle(6);
      check($sformatf("route%0d_count", d), oq[dests[d]].size(), 4);
      if (oq[dests[d]].size() > 0)
        check($sformatf("route%0d_head", d), oq[dests[d]][0], heads[d]);
      check($sformatf("route%0d_total", d), total_out(), 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
